// File: rtl/i2s_rx_ch_arbiter.sv
// Merges two I2S RX channel streams into one uDMA RX stream through per-channel elastic buffers.
// Latency: input valid in cycle t -> data_valid_o in t+2; valid/ready output holds data while stalled, overflow drops words and sets sticky err_o.
module i2s_rx_ch_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] ch0_data_i,
    input  logic                  ch0_valid_i,
    output logic                  ch0_ready_o,
    input  logic [DATA_WIDTH-1:0] ch1_data_i,
    input  logic                  ch1_valid_i,
    output logic                  ch1_ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  ch_sel_o,
    input  logic                  cfg_en_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic                  cfg_err_clr_i,
    output logic [1:0]            err_o
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] FULL_CNT = BUF_DEPTH[AW:0];

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [DATA_WIDTH-1:0] r_mem [2][BUF_DEPTH];
    ptr_t                  r_wptr [2];
    ptr_t                  r_rptr [2];
    cnt_t                  r_cnt  [2];
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_vld;
    logic                  r_sel;
    logic                  r_last;
    logic                  r_expect;
    logic [1:0]            r_err;

    logic [DATA_WIDTH-1:0] w_in_dat [2];
    logic [1:0]            w_in_vld;
    logic [1:0]            w_excl;
    logic [1:0]            w_full;
    logic [1:0]            w_nempty;
    logic [1:0]            w_grant;
    logic [1:0]            w_push;
    logic [1:0]            w_ovf;
    logic [1:0]            w_ready;
    logic                  w_slot_free;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_dat;

    always_comb begin
        w_in_dat[0] = ch0_data_i;
        w_in_dat[1] = ch1_data_i;
        w_in_vld    = {ch1_valid_i, ch0_valid_i};
        w_excl      = {cfg_mode_i == 2'b00, cfg_mode_i == 2'b01};
        for (int n = 0; n < 2; n++) begin
            w_full[n]   = (r_cnt[n] == FULL_CNT);
            w_nempty[n] = (r_cnt[n] != '0);
        end
        w_slot_free = !r_vld || data_ready_i;

        w_grant = 2'b00;
        case (cfg_mode_i)
            2'b00: w_grant = {1'b0, w_nempty[0]};
            2'b01: w_grant = {w_nempty[1], 1'b0};
            2'b10: begin
                // On a tie the channel not served last wins
                if (w_nempty[0] && w_nempty[1])
                    w_grant = r_last ? 2'b01 : 2'b10;
                else
                    w_grant = w_nempty;
            end
            default: w_grant = r_expect ? {w_nempty[1], 1'b0} : {1'b0, w_nempty[0]};
        endcase
        if (!cfg_en_i || !w_slot_free)
            w_grant = 2'b00;
        w_load     = |w_grant;
        w_load_dat = w_grant[1] ? r_mem[1][r_rptr[1]] : r_mem[0][r_rptr[0]];

        // A full buffer still takes a word when it is popped in the same cycle
        for (int n = 0; n < 2; n++) begin
            w_push[n]  = cfg_en_i && w_in_vld[n] && !w_excl[n] && (!w_full[n] || w_grant[n]);
            w_ovf[n]   = cfg_en_i && w_in_vld[n] && !w_excl[n] && w_full[n] && !w_grant[n];
            w_ready[n] = cfg_en_i && (w_excl[n] || !w_full[n]);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n])
                r_mem[n][r_wptr[n]] <= w_in_dat[n];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int n = 0; n < 2; n++) begin
                r_wptr[n] <= '0;
                r_rptr[n] <= '0;
                r_cnt[n]  <= '0;
            end
            r_dat    <= '0;
            r_vld    <= 1'b0;
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
            r_expect <= 1'b0;
            r_err    <= 2'b00;
        end else begin
            r_err <= cfg_err_clr_i ? 2'b00 : (r_err | w_ovf);
            if (!cfg_en_i) begin
                for (int n = 0; n < 2; n++) begin
                    r_wptr[n] <= '0;
                    r_rptr[n] <= '0;
                    r_cnt[n]  <= '0;
                end
                r_vld    <= 1'b0;
                r_last   <= 1'b1;
                r_expect <= 1'b0;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (w_push[n])
                        r_wptr[n] <= r_wptr[n] + ptr_t'(1);
                    if (w_grant[n])
                        r_rptr[n] <= r_rptr[n] + ptr_t'(1);
                    case ({w_push[n], w_grant[n]})
                        2'b10:   r_cnt[n] <= r_cnt[n] + cnt_t'(1);
                        2'b01:   r_cnt[n] <= r_cnt[n] - cnt_t'(1);
                        default: r_cnt[n] <= r_cnt[n];
                    endcase
                end
                if (w_load) begin
                    r_dat    <= w_load_dat;
                    r_vld    <= 1'b1;
                    r_sel    <= w_grant[1];
                    r_last   <= w_grant[1];
                    r_expect <= ~r_expect;
                end else if (data_ready_i) begin
                    r_vld <= 1'b0;
                end
            end
        end
    end

    assign ch0_ready_o  = w_ready[0];
    assign ch1_ready_o  = w_ready[1];
    assign data_o       = r_dat;
    assign data_valid_o = r_vld;
    assign ch_sel_o     = r_sel;
    assign err_o        = r_err;

endmodule

// File: tb/tb_i2s_rx_ch_arbiter.sv
// Bench for i2s_rx_ch_arbiter: queue-level reference model checked every cycle plus directed literal checks.
module tb_i2s_rx_ch_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic          rdy0, rdy1;
    logic [DW-1:0] data_o;
    logic          data_valid_o;
    logic          data_ready = 1'b0;
    logic          ch_sel_o;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          clr = 1'b0;
    logic [1:0]    err_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    i2s_rx_ch_arbiter #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .ch0_data_i(d0), .ch0_valid_i(v0), .ch0_ready_o(rdy0),
        .ch1_data_i(d1), .ch1_valid_i(v1), .ch1_ready_o(rdy1),
        .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready),
        .ch_sel_o(ch_sel_o), .cfg_en_i(en), .cfg_mode_i(mode),
        .cfg_err_clr_i(clr), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: word queues per channel and the single output slot
    logic [DW-1:0] q0[$], q1[$];
    logic [DW-1:0] m_dat;
    logic          m_vld, m_sel, m_last, m_exp;
    logic [1:0]    m_err;

    always @(posedge clk or negedge rstn) begin
        int g, s0, s1;
        logic [1:0] ovf;
        if (!rstn) begin
            q0.delete(); q1.delete();
            m_dat = '0; m_vld = 0; m_sel = 0; m_last = 1; m_exp = 0; m_err = 0;
        end else begin
            ovf = 2'b00;
            g = -1;
            if (!en) begin
                q0.delete(); q1.delete();
                m_vld = 0; m_last = 1; m_exp = 0;
            end else begin
                s0 = q0.size();
                s1 = q1.size();
                if (!m_vld || data_ready) begin
                    case (mode)
                        2'd0: if (s0 > 0) g = 0;
                        2'd1: if (s1 > 0) g = 1;
                        2'd2: begin
                            if (s0 > 0 && s1 > 0) g = m_last ? 0 : 1;
                            else if (s0 > 0) g = 0;
                            else if (s1 > 0) g = 1;
                        end
                        default: begin
                            if (!m_exp && s0 > 0) g = 0;
                            else if (m_exp && s1 > 0) g = 1;
                        end
                    endcase
                end
                if (g == 0) begin
                    m_dat = q0.pop_front(); m_sel = 0; m_vld = 1; m_last = 0; m_exp = !m_exp;
                end else if (g == 1) begin
                    m_dat = q1.pop_front(); m_sel = 1; m_vld = 1; m_last = 1; m_exp = !m_exp;
                end else if (data_ready) begin
                    m_vld = 0;
                end
                if (v0 && mode != 2'd1) begin
                    if (s0 < DEPTH || g == 0) q0.push_back(d0); else ovf[0] = 1;
                end
                if (v1 && mode != 2'd0) begin
                    if (s1 < DEPTH || g == 1) q1.push_back(d1); else ovf[1] = 1;
                end
            end
            m_err = clr ? 2'b00 : (m_err | ovf);
        end
    end

    typedef struct { logic sel; logic [DW-1:0] dat; int c; } out_t;
    out_t olog[$];

    always @(negedge clk) begin
        if (rstn) begin
            chk("valid", data_valid_o, m_vld);
            if (m_vld) begin
                chk("data", data_o, m_dat);
                chk("ch_sel", ch_sel_o, m_sel);
            end
            chk("err", err_o, m_err);
            chk("ready0", rdy0, en && (mode == 2'd1 || q0.size() < DEPTH));
            chk("ready1", rdy1, en && (mode == 2'd0 || q1.size() < DEPTH));
            if (data_valid_o && data_ready) olog.push_back('{ch_sel_o, data_o, cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_to(input logic [1:0] m);
        en = 0; v0 = 0; v1 = 0;
        step(); step();
        mode = m; en = 1;
        step();
        olog.delete();
    endtask

    task automatic chk_log(input string nm, input int idx, input logic sel, input logic [DW-1:0] dat);
        if (idx >= olog.size()) begin
            chk({nm, "_missing"}, 64'(olog.size()), 64'(idx + 1));
        end else begin
            chk({nm, "_dat"}, olog[idx].dat, dat);
            chk({nm, "_sel"}, olog[idx].sel, sel);
        end
    endtask

    initial begin
        int t0;
        logic [DW-1:0] exp_rr [6];
        #2;
        chk("rst_valid", data_valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_err", err_o, 0);
        step(); step();
        rstn = 1;
        step();
        chk("rst_sel", ch_sel_o, 0);
        chk("dis_ready0", rdy0, 0);
        chk("dis_ready1", rdy1, 0);

        // Mode 00: ch0 streams through, ch1 silently discarded
        mode = 2'b00; en = 1; data_ready = 1;
        step();
        olog.delete();
        for (int k = 0; k < 4; k++) begin
            d0 = 32'hA0 + k; v0 = 1; d1 = 32'h55; v1 = 1;
            if (k == 0) t0 = cyc;
            step();
            if (k == 0) chk("m0_ready1", rdy1, 1);
        end
        v0 = 0; v1 = 0;
        repeat (5) step();
        chk("m0_count", 64'(olog.size()), 4);
        for (int k = 0; k < 4; k++) begin
            chk_log("m0", k, 0, 32'hA0 + k);
            if (k < olog.size()) chk("m0_cycle", 64'(olog[k].c), 64'(t0 + 2 + k));
        end
        chk("m0_err", err_o, 0);

        // Mode 10: round-robin, ch0 wins the first tie
        flush_to(2'b10);
        for (int k = 0; k < 3; k++) begin
            d0 = 32'h10 + k; d1 = 32'h20 + k; v0 = 1; v1 = 1;
            step();
        end
        v0 = 0; v1 = 0;
        repeat (8) step();
        exp_rr = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22};
        chk("rr_count", 64'(olog.size()), 6);
        for (int k = 0; k < 6; k++) chk_log("rr", k, k[0], exp_rr[k]);
        chk("rr_err", err_o, 0);

        // Mode 11: ch1 waits until ch0 has been served
        flush_to(2'b11);
        d1 = 32'hB0; v1 = 1;
        step();
        v1 = 0;
        repeat (4) step();
        d0 = 32'hC0; v0 = 1;
        step();
        v0 = 0;
        repeat (5) step();
        chk("alt_count", 64'(olog.size()), 2);
        chk_log("alt0", 0, 0, 32'hC0);
        chk_log("alt1", 1, 1, 32'hB0);

        // Backpressure and overflow
        flush_to(2'b00);
        data_ready = 0;
        for (int k = 1; k <= 3; k++) begin
            d0 = k; v0 = 1;
            step();
        end
        d0 = 4; v0 = 1;
        @(negedge clk);
        chk("bp_ready0", rdy0, 0);
        step();
        v0 = 0;
        chk("bp_err", err_o, 2'b01);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_data", data_o, 1);
            chk("hold_sel", ch_sel_o, 0);
            chk("hold_valid", data_valid_o, 1);
        end
        clr = 1;
        step();
        clr = 0;
        chk("clr_err", err_o, 0);
        data_ready = 1;
        repeat (5) step();
        chk("bp_count", 64'(olog.size()), 3);
        for (int k = 0; k < 3; k++) chk_log("bp", k, 0, k + 1);

        // Flush with two buffered and one held word
        flush_to(2'b00);
        data_ready = 0;
        for (int k = 0; k < 3; k++) begin
            d0 = 32'h31 + k; v0 = 1;
            step();
        end
        en = 0; d0 = 32'h34; v0 = 1;
        step();
        v0 = 0;
        chk("flush_valid", data_valid_o, 0);
        chk("flush_err", err_o, 0);
        mode = 2'b11; en = 1; data_ready = 1;
        olog.delete();
        repeat (3) step();
        chk("flush_stale", 64'(olog.size()), 0);
        d0 = 32'hD0; d1 = 32'hD1; v0 = 1; v1 = 1;
        step();
        v0 = 0; v1 = 0;
        repeat (4) step();
        chk("reen_count", 64'(olog.size()), 2);
        chk_log("reen0", 0, 0, 32'hD0);
        chk_log("reen1", 1, 1, 32'hD1);

        // Asynchronous reset mid-transfer
        mode = 2'b00; data_ready = 0;
        for (int k = 0; k < 4; k++) begin
            d0 = 32'h41 + k; v0 = 1;
            step();
        end
        v0 = 0;
        chk("pre_rst_err", err_o, 2'b01);
        #3 rstn = 0;
        #1;
        chk("arst_valid", data_valid_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_data", data_o, 0);
        step();
        rstn = 1;
        data_ready = 1;
        olog.delete();
        repeat (5) step();
        chk("arst_no_out", 64'(olog.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
